// File: rtl/window_mask_scanner.sv
//==============================================================================
// window_mask_scanner - NCH-channel sliding-window mask generator with ready/valid
// stepping. Define WMS_CFG_ERR_EN to add the sticky o_cfg_err output. Rev 1.0
//==============================================================================
`default_nettype none

module window_mask_scanner #(
   parameter int GRID_W = 10,
   parameter int GRID_H = 10,
   parameter int NCH    = 3,
   parameter int DIM_W  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
   input  logic [NCH*DIM_W-1:0]          i_h,
   input  logic [NCH*DIM_W-1:0]          i_w,
   input  logic [NCH*DIM_W-1:0]          i_r,
   input  logic [NCH*DIM_W-1:0]          i_s,
   input  logic [NCH*DIM_W-1:0]          i_k,
   input  logic                          i_ready,
   output logic [NCH*GRID_W*GRID_H-1:0]  o_mask,
   output logic                          o_valid,
   output logic [NCH-1:0]                o_ch_active,
   output logic                          o_busy,
   output logic                          o_finish,
`ifdef WMS_CFG_ERR_EN
   output logic [NCH-1:0]                o_cfg_err,
`endif
   output logic [CNT_W-1:0]              o_step_cnt
);

   localparam int c_CELLS = GRID_W * GRID_H;
   // Position arithmetic is wide enough that pos+k+extent never wraps.
   localparam int c_SUMW  = $clog2(GRID_W + GRID_H) + 1;
   localparam int c_PW    = (DIM_W + 2 > c_SUMW) ? DIM_W + 2 : c_SUMW;
   localparam logic [c_PW-1:0] c_GW = c_PW'(GRID_W);
   localparam logic [c_PW-1:0] c_GH = c_PW'(GRID_H);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_start;
   logic             w_xfer;
   logic [NCH-1:0]   w_cfg_ok;
   logic [NCH-1:0]   w_live;
   logic [CNT_W-1:0] r_step_cnt;

   function automatic logic [c_CELLS-1:0] f_window(input logic [c_PW-1:0] row,
                                                   input logic [c_PW-1:0] col,
                                                   input logic [c_PW-1:0] h,
                                                   input logic [c_PW-1:0] w);
      logic [c_CELLS-1:0] m;
      m = '0;
      for (int rr = 0; rr < GRID_H; rr++) begin
         for (int cc = 0; cc < GRID_W; cc++) begin
            if (rr >= int'(row) && rr < int'(row) + int'(h) &&
                cc >= int'(col) && cc < int'(col) + int'(w))
               m[rr*GRID_W + cc] = 1'b1;
         end
      end
      return m;
   endfunction

   assign w_start = (r_state == S_IDLE) && i_start;
   assign w_xfer  = (r_state == S_RUN) && i_ready;

   generate
      for (genvar c = 0; c < NCH; c++) begin : g_ch
         logic [c_PW-1:0]    w_h, w_w, w_r, w_s, w_k;
         logic [c_PW-1:0]    r_h, r_w, r_s, r_k, r_row, r_col;
         logic [c_PW-1:0]    w_col_inc, w_col_nxt, w_row_nxt;
         logic               w_wrap, w_act_nxt;
         logic               r_act;
         logic [c_CELLS-1:0] r_mask;

         assign w_h = {{(c_PW-DIM_W){1'b0}}, i_h[c*DIM_W +: DIM_W]};
         assign w_w = {{(c_PW-DIM_W){1'b0}}, i_w[c*DIM_W +: DIM_W]};
         assign w_r = {{(c_PW-DIM_W){1'b0}}, i_r[c*DIM_W +: DIM_W]};
         assign w_s = {{(c_PW-DIM_W){1'b0}}, i_s[c*DIM_W +: DIM_W]};
         assign w_k = {{(c_PW-DIM_W){1'b0}}, i_k[c*DIM_W +: DIM_W]};

         assign w_cfg_ok[c] = (w_h != '0) && (w_w != '0) && (w_k != '0) &&
                              ((w_r + w_h) <= c_GH) && ((w_s + w_w) <= c_GW);

         // Step right; on overrunning the right edge return to the start column
         // and drop one stride.
         assign w_col_inc = r_col + r_k;
         assign w_wrap    = (w_col_inc + r_w) > c_GW;
         assign w_col_nxt = w_wrap ? r_s : w_col_inc;
         assign w_row_nxt = w_wrap ? (r_row + r_k) : r_row;
         assign w_act_nxt = r_act && ((w_row_nxt + r_h) <= c_GH);
         assign w_live[c] = w_act_nxt;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_h    <= '0;
               r_w    <= '0;
               r_s    <= '0;
               r_k    <= '0;
               r_row  <= '0;
               r_col  <= '0;
               r_act  <= 1'b0;
               r_mask <= '0;
            end else if (w_start) begin
               r_h    <= w_h;
               r_w    <= w_w;
               r_s    <= w_s;
               r_k    <= w_k;
               r_row  <= w_r;
               r_col  <= w_s;
               r_act  <= w_cfg_ok[c];
               r_mask <= w_cfg_ok[c] ? f_window(w_r, w_s, w_h, w_w) : '0;
            end else if (w_xfer && r_act) begin
               r_row  <= w_row_nxt;
               r_col  <= w_col_nxt;
               r_act  <= w_act_nxt;
               r_mask <= w_act_nxt ? f_window(w_row_nxt, w_col_nxt, r_h, r_w) : '0;
            end
         end

         assign o_mask[c*c_CELLS +: c_CELLS] = r_mask;
         assign o_ch_active[c]               = r_act;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (i_start) w_state_nxt = (|w_cfg_ok) ? S_RUN : S_DONE;
         S_RUN:  if (i_ready && !(|w_live)) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_step_cnt <= '0;
      else if (w_start)
         r_step_cnt <= '0;
      else if (w_xfer && (r_step_cnt != {CNT_W{1'b1}}))
         r_step_cnt <= r_step_cnt + CNT_W'(1);
   end

`ifdef WMS_CFG_ERR_EN
   logic [NCH-1:0] r_cfg_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_cfg_err <= '0;
      else if (w_start)
         r_cfg_err <= ~w_cfg_ok;
   end

   assign o_cfg_err = r_cfg_err;
`endif

   assign o_valid    = (r_state == S_RUN);
   assign o_busy     = (r_state != S_IDLE);
   assign o_finish   = (r_state == S_DONE);
   assign o_step_cnt = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_window_mask_scanner.sv
//==============================================================================
// tb_window_mask_scanner - randomized bench with a window-enumeration reference
// model for window_mask_scanner. Rev 1.0
//==============================================================================
`default_nettype none

module tb_window_mask_scanner;

   localparam int GW  = 10;
   localparam int GH  = 10;
   localparam int NCH = 3;
   localparam int DW  = 4;
   localparam int CW  = 8;
   localparam int MB  = GW * GH;
   localparam int TW  = NCH * MB;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              ready = 1'b1;
   logic [NCH*DW-1:0] h = '0, w = '0, r = '0, s = '0, k = '0;
   logic [TW-1:0]     o_mask;
   logic              o_valid, o_busy, o_finish;
   logic [NCH-1:0]    o_ch_active;
   logic [CW-1:0]     o_step_cnt;
`ifdef WMS_CFG_ERR_EN
   logic [NCH-1:0]    o_cfg_err;
`endif

   window_mask_scanner #(.GRID_W(GW), .GRID_H(GH), .NCH(NCH), .DIM_W(DW), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_h(h), .i_w(w), .i_r(r), .i_s(s), .i_k(k), .i_ready(ready),
      .o_mask(o_mask), .o_valid(o_valid), .o_ch_active(o_ch_active),
      .o_busy(o_busy), .o_finish(o_finish),
`ifdef WMS_CFG_ERR_EN
      .o_cfg_err(o_cfg_err),
`endif
      .o_step_cnt(o_step_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int ready_mode = 0;
   int ready_ph = 0;

   // Reference model: every window of a channel is enumerated up front in scan
   // order; the scan then just walks an index through those lists.
   int             m_phase = 0;   // 0 idle, 1 scanning, 2 finishing
   int             m_idx = 0;
   int             m_total = 0;
   int             m_cnt = 0;
   int             m_len [NCH];
   logic [MB-1:0]  m_win [NCH][MB];
   logic [NCH-1:0] m_err = '0;

   task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [MB-1:0] rect(input int row, input int col, input int hh, input int ww);
      logic [MB-1:0] m;
      m = '0;
      for (int y = row; y < row + hh; y++)
         for (int x = col; x < col + ww; x++)
            m[y*GW + x] = 1'b1;
      return m;
   endfunction

   task automatic build_model();
      m_total = 0;
      for (int c = 0; c < NCH; c++) begin
         int hh, ww, rr, ss, kk;
         bit ok;
         hh = int'(h[c*DW +: DW]);
         ww = int'(w[c*DW +: DW]);
         rr = int'(r[c*DW +: DW]);
         ss = int'(s[c*DW +: DW]);
         kk = int'(k[c*DW +: DW]);
         ok = hh > 0 && ww > 0 && kk > 0 && rr + hh <= GH && ss + ww <= GW;
         m_err[c] = !ok;
         m_len[c] = 0;
         if (ok) begin
            for (int row = rr; row + hh <= GH; row += kk)
               for (int col = ss; col + ww <= GW; col += kk) begin
                  m_win[c][m_len[c]] = rect(row, col, hh, ww);
                  m_len[c]++;
               end
         end
         if (m_len[c] > m_total) m_total = m_len[c];
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_idx = 0; m_total = 0; m_cnt = 0; m_err = '0;
      end else begin
         case (m_phase)
            0: if (start) begin
                  build_model();
                  m_idx = 0;
                  m_cnt = 0;
                  m_phase = (m_total > 0) ? 1 : 2;
               end
            1: if (ready) begin
                  m_idx++;
                  if (m_cnt < (1 << CW) - 1) m_cnt++;
                  if (m_idx >= m_total) m_phase = 2;
               end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [TW-1:0]  em;
      logic [NCH-1:0] ea;
      em = '0;
      ea = '0;
      for (int c = 0; c < NCH; c++) begin
         if (m_phase == 1 && m_idx < m_len[c]) begin
            em[c*MB +: MB] = m_win[c][m_idx];
            ea[c] = 1'b1;
         end
      end
      chk("valid",     TW'(o_valid),     TW'(m_phase == 1));
      chk("busy",      TW'(o_busy),      TW'(m_phase != 0));
      chk("finish",    TW'(o_finish),    TW'(m_phase == 2));
      chk("step_cnt",  TW'(o_step_cnt),  TW'(m_cnt));
      chk("ch_active", TW'(o_ch_active), TW'(ea));
      chk("mask",      o_mask,           em);
`ifdef WMS_CFG_ERR_EN
      chk("cfg_err",   TW'(o_cfg_err),   TW'(m_err));
`endif
   end

   task automatic tick();
      @(negedge clk);
      #1;
      case (ready_mode)
         0: ready = 1'b1;
         1: begin ready = (ready_ph % 3 == 0); ready_ph++; end
         default: ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   function automatic logic [NCH*DW-1:0] pk(input int a0, input int a1, input int a2);
      logic [NCH*DW-1:0] v;
      v = '0;
      v[0 +: DW]    = DW'(a0);
      v[DW +: DW]   = DW'(a1);
      v[2*DW +: DW] = DW'(a2);
      return v;
   endfunction

   task automatic begin_scan(input logic [NCH*DW-1:0] hh, ww, rr, ss, kk);
      h = hh; w = ww; r = rr; s = ss; k = kk;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input bit inject);
      bit done;
      done = 0;
      for (int i = 0; i < 3000; i++) begin
         start = inject && (i == 2);
         tick();
         if (!o_busy) begin done = 1; break; end
      end
      start = 1'b0;
      chk("scan_timeout", TW'(done), TW'(1'b1));
   endtask

   logic [MB-1:0] lit;

   initial begin
      repeat (3) tick();
      chk("reset_state", TW'({o_valid, o_busy, o_finish, o_step_cnt, o_ch_active}), '0);
      chk("reset_mask", o_mask, '0);
      rst_n = 1'b1;
      tick();

      // ch0 alone: 3x3 grid of 2x2 windows
      begin_scan(pk(2,0,0), pk(2,0,0), pk(0,0,0), pk(0,0,0), pk(4,0,0));
      wait_idle(0);
      chk("model_len0", TW'(m_len[0]), TW'(9));
      lit = '0; lit[0] = 1; lit[1] = 1; lit[10] = 1; lit[11] = 1;
      chk("model_ch0_first", TW'(m_win[0][0]), TW'(lit));
      lit = '0; lit[88] = 1; lit[89] = 1; lit[98] = 1; lit[99] = 1;
      chk("model_ch0_last", TW'(m_win[0][8]), TW'(lit));
      chk("steps_ch0", TW'(o_step_cnt), TW'(9));

      // ch0 + ch1
      begin_scan(pk(2,3,0), pk(2,5,0), pk(0,1,0), pk(0,2,0), pk(4,3,0));
      wait_idle(0);
      chk("model_len1", TW'(m_len[1]), TW'(6));
      lit = '0;
      for (int y = 1; y <= 3; y++) for (int x = 2; x <= 6; x++) lit[y*GW + x] = 1;
      chk("model_ch1_first", TW'(m_win[1][0]), TW'(lit));
      lit = '0;
      for (int y = 7; y <= 9; y++) for (int x = 5; x <= 9; x++) lit[y*GW + x] = 1;
      chk("model_ch1_last", TW'(m_win[1][5]), TW'(lit));
      chk("steps_ch01", TW'(o_step_cnt), TW'(9));

      // same config under 1,0,0 back-pressure
      ready_mode = 1;
      begin_scan(pk(2,3,0), pk(2,5,0), pk(0,1,0), pk(0,2,0), pk(4,3,0));
      wait_idle(0);
      chk("steps_stall", TW'(o_step_cnt), TW'(9));
      ready_mode = 0;

      // no valid channel: straight to finish
      begin_scan(pk(2,2,2), pk(2,2,2), pk(0,0,0), pk(0,0,0), pk(0,0,0));
      chk("k0_finish", TW'({o_finish, o_valid}), TW'(2'b10));
`ifdef WMS_CFG_ERR_EN
      chk("k0_cfg_err", TW'(o_cfg_err), TW'(3'b111));
`endif
      wait_idle(0);

      // start during RUN ignored; start right after finish honoured
      begin_scan(pk(2,0,0), pk(2,0,0), pk(0,0,0), pk(0,0,0), pk(4,0,0));
      wait_idle(1);
      chk("steps_ignored_start", TW'(o_step_cnt), TW'(9));
      begin_scan(pk(2,0,0), pk(2,0,0), pk(0,0,0), pk(0,0,0), pk(4,0,0));
      chk("restart_valid", TW'(o_valid), TW'(1'b1));
      wait_idle(0);

      // reset two cycles into a scan
      begin_scan(pk(2,3,0), pk(2,5,0), pk(0,1,0), pk(0,2,0), pk(4,3,0));
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset", TW'({o_valid, o_busy, o_finish, o_step_cnt, o_ch_active}), '0);
      chk("midrun_reset_mask", o_mask, '0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      begin_scan(pk(2,3,0), pk(2,5,0), pk(0,1,0), pk(0,2,0), pk(4,3,0));
      wait_idle(0);
      chk("steps_after_reset", TW'(o_step_cnt), TW'(9));

      // randomized geometry and back-pressure
      ready_mode = 2;
      for (int n = 0; n < 25; n++) begin
         logic [NCH*DW-1:0] rh, rw, rr, rs, rk;
         for (int c = 0; c < NCH; c++) begin
            rh[c*DW +: DW] = DW'($urandom_range(0, 5));
            rw[c*DW +: DW] = DW'($urandom_range(0, 5));
            rr[c*DW +: DW] = DW'($urandom_range(0, 9));
            rs[c*DW +: DW] = DW'($urandom_range(0, 9));
            rk[c*DW +: DW] = DW'($urandom_range(0, 4));
         end
         begin_scan(rh, rw, rr, rs, rk);
         wait_idle(n % 4 == 1);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/window_mask_scanner.md
Name: window_mask_scanner

Overview:
- Parametrised multi-channel sliding-window mask generator for the object-tracking datapath.
- Successor to the fixed three-region, 10x10 address process.
- Per start, scans NCH independent rectangular windows across a GRID_H x GRID_W grid in lockstep, emitting one bitmask per channel per accepted step.
- Supports a ready/valid back-pressure handshake so downstream region-comparison/count logic can stall it.

Parameters:
- GRID_W, 10, grid columns
- GRID_H, 10, grid rows
- NCH, 3, number of window channels
- DIM_W, 4, width of each per-channel geometry field
- CNT_W, 8, width of step counter

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; honoured only in IDLE
- i_h  in  NCH*DIM_W  window height per channel; channel c at [c*DIM_W +: DIM_W]; same packing for i_w, i_r, i_s, i_k
- i_w  in  NCH*DIM_W  window width
- i_r  in  NCH*DIM_W  initial top row
- i_s  in  NCH*DIM_W  initial left column
- i_k  in  NCH*DIM_W  stride, applied to both row and column
- i_ready  in  1  consumer accepts current mask
- o_mask  out  NCH*GRID_W*GRID_H  channel c at [c*GRID_W*GRID_H +: GRID_W*GRID_H]; bit row*GRID_W+col set when that cell is inside the window
- o_valid  out  1  o_mask valid
- o_ch_active  out  NCH  channel still producing windows
- o_busy  out  1  scan in progress
- o_finish  out  1  one-cycle pulse at scan end
- o_step_cnt  out  CNT_W  accepted steps in current/last scan

Behaviour:
- Reset (async, i_rst_n low): state IDLE; o_mask=0, o_valid=0, o_ch_active=0, o_busy=0, o_finish=0, o_step_cnt=0. Reset mid-scan aborts immediately with no finish pulse.
- States:
  - IDLE -> RUN on i_start.
  - RUN -> DONE when the last active channel's final window is accepted.
  - DONE -> IDLE unconditionally after one cycle. o_finish=1 in DONE only.
- Start (edge n): latch all geometry; per channel position (row=r, col=s). Channel valid iff h>0, w>0, k>0, r+h<=GRID_H, s+w<=GRID_W; invalid channels have o_ch_active=0 for the whole scan. o_step_cnt cleared. First o_valid at edge n+1 (one-cycle latency).
- If no channel is valid: RUN is skipped, IDLE->DONE at n+1, o_valid never asserts.
- Fit checks use DIM_W+1-bit sums; no overflow.
- Step: a transfer occurs on o_valid && i_ready. On each transfer, every active channel advances:
  - col += k.
  - If the new col+w > GRID_W: col = s and row += k.
  - If the new row+h > GRID_H: the channel deactivates.
  - o_step_cnt += 1, saturating at all-ones.
- Stall: o_valid && !i_ready holds o_mask, positions and counters unchanged.
- o_mask for an inactive channel is all zeros. Masks are registered and change only on transfer or start.
- o_valid stays high continuously through RUN; it drops in the cycle the last channel deactivates.
- i_start during RUN/DONE is ignored. i_start in the IDLE cycle directly after DONE is honoured.
- o_busy=1 in RUN and DONE.

Optional Feature:
- Macro WMS_CFG_ERR_EN.
- Defined: adds output o_cfg_err [NCH]. At start, bit c is set if channel c fails the validity check; it is sticky until the next accepted i_start. Reset value is 0.
- Undefined: port absent; invalid channels are silently inactive. All other behaviour is identical.

Test Plan:
- Reset mid-RUN (drop i_rst_n two cycles after start) -> all outputs 0 asynchronously; no o_finish; a later start scans normally.
- Defaults, ch0 h=2 w=2 r=0 s=0 k=4, others zeroed, i_ready=1 -> 9 masks; the first has bits {0,1,10,11}, the last has {88,89,98,99}; o_finish one cycle after the 9th transfer; o_step_cnt=9.
- ch0 as above plus ch1 h=3 w=5 r=1 s=2 k=3:
  - ch1 emits 6 windows, first {12..16, 22..26, 32..36}, last at row7 col5.
  - o_ch_active[1] falls after transfer 6; ch1 mask 0 afterwards.
  - Total 9 steps.
- Same config with i_ready toggling 1,0,0,1,... -> mask sequence identical to the i_ready=1 run; no step is lost or duplicated during stalls.
- All channels k=0 -> no o_valid; o_finish at start+1 cycle. With WMS_CFG_ERR_EN, o_cfg_err=3'b111.
- i_start pulsed during RUN -> ignored; scan count unchanged. i_start the cycle after o_finish -> new scan begins, first valid one cycle later.
